// File: rtl/ballot_pkg.sv
// ballot_pkg
// Shared types and constants for the ballot collector slice.
//   state_t          : collector FSM state encoding (IDLE / COLLECT / PRESENT)
//   N_VOTERS         : number of voters feeding one ballot
//   VOTER_ID_W       : width of a voter index
//   DEFAULT_TIMEOUT  : default COLLECT-phase cycle budget
//   TIMER_W          : width of the COLLECT-phase cycle counter
package ballot_pkg;

    localparam int N_VOTERS        = 4;
    localparam int VOTER_ID_W      = 2;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int TIMER_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // One-hot select of a voter bit; keeps the mask/ballot update expressions short.
    function automatic logic [N_VOTERS-1:0] voter_bit(input logic [VOTER_ID_W-1:0] id);
        voter_bit = '0;
        voter_bit[id] = 1'b1;
    endfunction

endpackage

// File: rtl/ballot_timer.sv
// ballot_timer
// Counts COLLECT-phase cycles and flags the last permitted cycle.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   i_clear   in   force the count back to 0
//   i_enable  in   advance the count by one this cycle
//   o_expire  out  count equals TIMEOUT_CYC-1 (last COLLECT cycle)
module ballot_timer
    import ballot_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TIMER_W-1:0] LP_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LP_LAST);

endmodule

// File: rtl/ballot_collector.sv
// ballot_collector
// Gathers one vote from each of four voters into a ballot, closing the round
// either when every voter has voted or when the COLLECT cycle budget runs out,
// then presents the ballot until the downstream side acknowledges it.
// Optional feature: define BALLOT_DUP_ERR_EN to add the sticky dup_err output.
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   open_round    in   pulse that starts a round (honoured in IDLE only)
//   vote_valid    in   vote offered this cycle
//   vote_id       in   voter index 0..3
//   vote_val      in   vote value (1 = yes)
//   vote_ready    out  collector accepts votes (COLLECT state)
//   Out           out  assembled ballot, bit i = vote of voter i
//   ballot_valid  out  Out holds a closed ballot (PRESENT state)
//   ballot_ack    in   downstream consumed the ballot (honoured in PRESENT only)
//   voted_mask    out  bit i set once voter i has voted this round
//   timed_out     out  current/last round closed by timeout
//   o_dbg_state   out  FSM state, for observation
//   dup_err       out  (BALLOT_DUP_ERR_EN only) sticky repeat-vote flag
//
// Handshake: a vote transfers on a rising edge where vote_valid and vote_ready
// are both 1; repeat votes from the same voter are dropped. The ballot transfers
// on a rising edge where ballot_valid and ballot_ack are both 1.
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  open_round,
    input  logic                  vote_valid,
    input  logic [VOTER_ID_W-1:0] vote_id,
    input  logic                  vote_val,
    output logic                  vote_ready,
    output logic [N_VOTERS-1:0]   Out,
    output logic                  ballot_valid,
    input  logic                  ballot_ack,
    output logic [N_VOTERS-1:0]   voted_mask,
    output logic                  timed_out,
`ifdef BALLOT_DUP_ERR_EN
    output logic                  dup_err,
`endif
    output logic [1:0]            o_dbg_state
);

    state_t              r_state;
    state_t              w_next_state;
    logic [N_VOTERS-1:0] r_out;
    logic [N_VOTERS-1:0] r_mask;
    logic                r_timed_out;

    logic                w_in_collect;
    logic                w_accept;
    logic [N_VOTERS-1:0] w_mask_next;
    logic                w_expire;
    logic                w_set_timeout;
    logic                w_start;

    assign w_in_collect = (r_state == ST_COLLECT);
    assign w_start      = (r_state == ST_IDLE) && open_round;
    assign w_accept     = w_in_collect && vote_valid && !r_mask[vote_id];
    // Mask as it will be after this edge; completion is judged on this so a
    // vote landing on the final budget cycle still counts as a full ballot.
    assign w_mask_next  = w_accept ? (r_mask | voter_bit(vote_id)) : r_mask;

    // Timer is held at 0 outside COLLECT, so the first COLLECT cycle is count 0.
    ballot_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_in_collect),
        .i_enable (w_in_collect),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next_state  = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (open_round) begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (&w_mask_next) begin
                    w_next_state = ST_PRESENT;
                end else if (w_expire) begin
                    w_next_state  = ST_PRESENT;
                    w_set_timeout = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (ballot_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_mask      <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_out       <= '0;
                r_mask      <= '0;
                r_timed_out <= 1'b0;
            end else if (w_in_collect) begin
                if (w_accept) begin
                    r_out[vote_id] <= vote_val;
                end
                r_mask <= w_mask_next;
                if (w_set_timeout) begin
                    r_timed_out <= 1'b1;
                end
            end
        end
    end

`ifdef BALLOT_DUP_ERR_EN
    logic r_dup_err;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_dup_err <= 1'b0;
        end else if (w_in_collect && vote_valid && r_mask[vote_id]) begin
            r_dup_err <= 1'b1;
        end
    end

    assign dup_err = r_dup_err;
`endif

    assign vote_ready   = w_in_collect;
    assign ballot_valid = (r_state == ST_PRESENT);
    assign Out          = r_out;
    assign voted_mask   = r_mask;
    assign timed_out    = r_timed_out;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector
// Directed-vector bench for ballot_collector (TIMEOUT_CYC = 8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_ballot_collector;
    import ballot_pkg::*;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       open_round;
    logic       vote_valid;
    logic [1:0] vote_id;
    logic       vote_val;
    logic       vote_ready;
    logic [3:0] Out;
    logic       ballot_valid;
    logic       ballot_ack;
    logic [3:0] voted_mask;
    logic       timed_out;
    logic [1:0] dbg_state;
`ifdef BALLOT_DUP_ERR_EN
    logic       dup_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ballot_collector #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .open_round   (open_round),
        .vote_valid   (vote_valid),
        .vote_id      (vote_id),
        .vote_val     (vote_val),
        .vote_ready   (vote_ready),
        .Out          (Out),
        .ballot_valid (ballot_valid),
        .ballot_ack   (ballot_ack),
        .voted_mask   (voted_mask),
        .timed_out    (timed_out),
`ifdef BALLOT_DUP_ERR_EN
        .dup_err      (dup_err),
`endif
        .o_dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(input logic [1:0] id, input logic v);
        vote_valid = 1'b1;
        vote_id    = id;
        vote_val   = v;
        step();
        vote_valid = 1'b0;
    endtask

    task automatic open();
        open_round = 1'b1;
        step();
        open_round = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_out"},   int'(Out),          0);
        check({tag, "_bv"},    int'(ballot_valid), 0);
        check({tag, "_rdy"},   int'(vote_ready),   0);
        check({tag, "_mask"},  int'(voted_mask),   0);
        check({tag, "_to"},    int'(timed_out),    0);
        check({tag, "_state"}, int'(dbg_state),    int'(ST_IDLE));
    endtask

    task automatic check_ballot(input string tag, input int exp_out,
                                input int exp_mask, input int exp_to);
        check({tag, "_bv"},    int'(ballot_valid), 1);
        check({tag, "_rdy"},   int'(vote_ready),   0);
        check({tag, "_out"},   int'(Out),          exp_out);
        check({tag, "_mask"},  int'(voted_mask),   exp_mask);
        check({tag, "_to"},    int'(timed_out),    exp_to);
    endtask

    initial begin
        rst        = 1'b1;
        open_round = 1'b0;
        vote_valid = 1'b0;
        vote_id    = 2'd0;
        vote_val   = 1'b0;
        ballot_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle_zero("reset");

        // Full round, back-to-back votes: ballot on the 5th edge after open.
        open();
        check("open_rdy",   int'(vote_ready),   1);
        check("open_state", int'(dbg_state),    int'(ST_COLLECT));
        check("open_bv",    int'(ballot_valid), 0);
        vote(2'd0, 1'b1);
        vote(2'd1, 1'b0);
        vote(2'd2, 1'b1);
        check("full_mask3", int'(voted_mask),   4'b0111);
        check("full_bv3",   int'(ballot_valid), 0);
        vote(2'd3, 1'b1);
        check_ballot("full", 4'b1101, 4'b1111, 0);
        ballot_ack = 1'b1;
        step();
        ballot_ack = 1'b0;
        check("ack_state", int'(dbg_state),    int'(ST_IDLE));
        check("ack_bv",    int'(ballot_valid), 0);

        // Ack withheld for 10 cycles while votes and open_round are pulsed.
        open();
        vote(2'd3, 1'b0);
        vote(2'd0, 1'b0);
        vote(2'd2, 1'b1);
        vote(2'd1, 1'b1);
        check_ballot("hold0", 4'b0110, 4'b1111, 0);
        for (int i = 0; i < 10; i++) begin
            open_round = i[0];
            vote_valid = 1'b1;
            vote_id    = 2'(i);
            vote_val   = ~i[1];
            step();
            check_ballot($sformatf("hold%0d", i + 1), 4'b0110, 4'b1111, 0);
        end
        open_round = 1'b0;
        vote_valid = 1'b0;
        ballot_ack = 1'b1;
        step();
        ballot_ack = 1'b0;
        check("hold_ack_state", int'(dbg_state), int'(ST_IDLE));

        // Timeout: only voter 2 votes, closes after 8 COLLECT cycles.
        open();
        check("to_clr_out", int'(Out), 0);
        vote(2'd2, 1'b1);
        for (int i = 0; i < TO - 2; i++) step();
        check("to_pre_state", int'(dbg_state), int'(ST_COLLECT));
        check("to_pre_to",    int'(timed_out), 0);
        step();
        check_ballot("timeout", 4'b0100, 4'b0100, 1);
        ballot_ack = 1'b1;
        step();
        ballot_ack = 1'b0;

        // Repeat vote from voter 1 is dropped.
        open();
        check("dup_clr_to", int'(timed_out), 0);
        vote(2'd1, 1'b1);
        vote(2'd1, 1'b0);
        check("dup_out",  int'(Out),        4'b0010);
        check("dup_mask", int'(voted_mask), 4'b0010);
`ifdef BALLOT_DUP_ERR_EN
        check("dup_err_set", int'(dup_err), 1);
`endif
        for (int i = 0; i < TO - 2; i++) step();
        check_ballot("dup_to", 4'b0010, 4'b0010, 1);
        ballot_ack = 1'b1;
        step();
        ballot_ack = 1'b0;
`ifdef BALLOT_DUP_ERR_EN
        check("dup_err_idle", int'(dup_err), 1);
`endif

        // Completing vote on the last budget cycle; ack ignored during COLLECT.
        open();
        check("late_clr_to",   int'(timed_out),  0);
        check("late_clr_mask", int'(voted_mask), 0);
`ifdef BALLOT_DUP_ERR_EN
        check("dup_err_clr", int'(dup_err), 0);
`endif
        vote(2'd0, 1'b0);
        vote(2'd1, 1'b1);
        vote(2'd2, 1'b0);
        ballot_ack = 1'b1;
        step();
        ballot_ack = 1'b0;
        check("late_ack_ign", int'(dbg_state), int'(ST_COLLECT));
        step();
        step();
        step();
        check("late_pre", int'(dbg_state), int'(ST_COLLECT));
        vote(2'd3, 1'b1);
        check_ballot("late", 4'b1010, 4'b1111, 0);
        ballot_ack = 1'b1;
        step();
        ballot_ack = 1'b0;

        // Reset held 2 cycles mid-COLLECT with two votes in, competing inputs high.
        open();
        vote(2'd0, 1'b1);
        vote(2'd3, 1'b1);
        rst        = 1'b1;
        open_round = 1'b1;
        vote_valid = 1'b1;
        vote_id    = 2'd1;
        vote_val   = 1'b1;
        ballot_ack = 1'b1;
        step();
        step();
        rst        = 1'b0;
        open_round = 1'b0;
        vote_valid = 1'b0;
        ballot_ack = 1'b0;
        check_idle_zero("rst_col");

        // Reset in PRESENT.
        open();
        vote(2'd0, 1'b1);
        vote(2'd1, 1'b1);
        vote(2'd2, 1'b1);
        vote(2'd3, 1'b1);
        check("rstp_bv", int'(ballot_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_zero("rst_pres");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
